spart_echo_ctrl: RTL and testbench
==================================

Name: spart_echo_ctrl

Overview:
- Bus master for the SPART processor interface (iocs/iorw/ioaddr/databus).
- After reset, programs the baud divisor selected by br_cfg into the SPART divisor registers.
- Then runs an echo loop: received bytes are read into a 4-entry buffer and written back to the transmitter.
- A single-master arbiter shares the one bus between receive reads and transmit writes.

Parameters:
- DIV_0, 16'h0515, divisor for br_cfg=00 (4800 baud @100 MHz, 16x)
- DIV_1, 16'h028A, divisor for br_cfg=01 (9600)
- DIV_2, 16'h0145, divisor for br_cfg=10 (19200)
- DIV_3, 16'h00A2, divisor for br_cfg=11 (38400)
- DEPTH, 4, echo buffer entries (power of 2, ≥2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- br_cfg  in  2  baud select; static or changed only while running
- rda  in  1  SPART receive data available
- tbr  in  1  SPART transmit buffer ready
- iocs  out  1  SPART chip select, active high, one-cycle pulse per access
- iorw  out  1  1 = read, 0 = write
- ioaddr  out  2  00 = TX/RX data, 01 = status, 10 = divisor low, 11 = divisor high
- databus  inout  8  driven by this block only during write cycles; Z otherwise
- cfg_done  out  1  high once both divisor bytes are written
- buf_level  out  3  current echo buffer occupancy, 0..DEPTH

Behaviour:
- Reset (rst=0 at posedge clk): iocs=0, iorw=1, ioaddr=00, databus=Z, cfg_done=0, buf_level=0, buffer pointers=0, state=CFG_LO, rr_last=WRITE. Reset mid-access aborts the access immediately; no partial state is kept.
- Bus access rule: every access is exactly one cycle with iocs=1, followed by one mandatory GAP cycle with iocs=0. The GAP lets SPART update rda/tbr. Maximum rate is therefore one access per 2 cycles.
- The divisor is selected from the br_cfg value registered at entry to CFG_LO (cfg_sel).
- State machine:
  - CFG_LO: iocs=1, iorw=0, ioaddr=10, databus=DIVn[7:0] -> GAP_CFG.
  - GAP_CFG: -> CFG_HI.
  - CFG_HI: iocs=1, iorw=0, ioaddr=11, databus=DIVn[15:8] -> GAP; cfg_done=1 from the next cycle.
  - RUN: arbitrate as below; idle (iocs=0) if nothing is eligible.
  - RD: iocs=1, iorw=1, ioaddr=00. Capture databus at the end of the cycle into buffer[wptr]; wptr++, level++ -> GAP.
  - WR: iocs=1, iorw=0, ioaddr=00, databus=buffer[rptr]; rptr++, level-- -> GAP.
  - GAP: -> RUN. Exception: if br_cfg != cfg_sel, go -> CFG_LO with cfg_done=0; buffer contents are kept.
- Arbitration in RUN:
  - Read is eligible when rda=1 and level<DEPTH.
  - Write is eligible when tbr=1 and level>0.
  - Both eligible: grant the opposite of rr_last (round robin); rr_last updates on each grant.
- Boundaries:
  - Buffer full: reads are blocked and the byte stays in SPART. Write-only traffic continues.
  - Buffer empty: writes are blocked.
  - Pointers wrap modulo DEPTH.
  - A br_cfg change during RD/WR is acted on only at the following GAP, so the access always completes.
  - br_cfg changes during CFG_* are ignored until the next GAP after CFG_HI.
- databus is driven only in CFG_LO, CFG_HI and WR; it is Z in every other state and in reset.

Optional Feature:
- Macro UPCASE_ECHO_EN.
- Defined: in WR, bytes 8'h61–8'h7A ('a'–'z') are transmitted minus 8'h20. All other bytes pass through unchanged. Buffer contents are stored unconverted.
- Undefined: bytes are echoed unmodified.
- Latency and handshake are identical in both builds.

Test Plan:
- Reset with br_cfg=01, release -> writes addr 10 data 8A, then addr 11 data 02, each as a one-cycle iocs pulse two cycles apart; cfg_done=1 on the cycle after the second GAP starts.
- rda=1 with SPART driving 8'h41, tbr=1 -> RD capturing 41, GAP, then WR addr 00 data 41; buf_level goes 0->1->0.
- tbr=0, rda held 1 with bytes 10,11,12,13,14 -> four RDs, buf_level=4, no fifth iocs. Then tbr=1 -> WR 10, after which the fifth read occurs; output order is 10..14.
- rda=1 and tbr=1 continuously with level=2 -> iocs accesses alternate RD/WR (round robin); never two iocs cycles back to back.
- After cfg_done, change br_cfg 01->11 -> the pending access completes, then a CFG sequence writes A2/00; buffered bytes are still echoed afterwards.
- UPCASE_ECHO_EN defined, receive 8'h61 then 8'h5A -> transmits 8'h41 then 8'h5A. Macro undefined -> transmits 8'h61 then 8'h5A.

Source files
------------

// File: rtl/spart_echo_ctrl.sv
// SPART bus master: programs the baud divisor, then echoes received bytes through a small buffer.
// Optional build macro UPCASE_ECHO_EN: transmit lower-case ASCII as upper case.
module spart_echo_ctrl #(
  parameter logic [15:0] DIV_0 = 16'h0515,
  parameter logic [15:0] DIV_1 = 16'h028A,
  parameter logic [15:0] DIV_2 = 16'h0145,
  parameter logic [15:0] DIV_3 = 16'h00A2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               br_cfg,
  input  logic                     rda,
  input  logic                     tbr,
  output logic                     iocs,
  output logic                     iorw,
  output logic [1:0]               ioaddr,
  inout  wire  [7:0]               databus,
  output logic                     cfg_done,
  output logic [$clog2(DEPTH):0]   buf_level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  typedef enum logic [2:0] {
    StCfgLo,
    StGapCfg,
    StCfgHi,
    StRun,
    StRd,
    StWr,
    StGap
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        cfg_sel_q, cfg_sel_d;
  logic              cfg_done_q, cfg_done_d;
  logic              rr_wr_q, rr_wr_d;
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [LvlW-1:0]   level_q, level_d;
  logic [7:0]        buf_q [DEPTH];

  logic              iocs_c, iorw_c, drive_c;
  logic [1:0]        ioaddr_c;
  logic [7:0]        dout_c;
  logic [15:0]       div_sel;
  logic              rd_ok, wr_ok;

`ifdef UPCASE_ECHO_EN
  function automatic logic [7:0] echo_byte(input logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
    return b;
  endfunction
`else
  function automatic logic [7:0] echo_byte(input logic [7:0] b);
    return b;
  endfunction
`endif

  always_comb begin
    unique case (cfg_sel_q)
      2'b00:   div_sel = DIV_0;
      2'b01:   div_sel = DIV_1;
      2'b10:   div_sel = DIV_2;
      default: div_sel = DIV_3;
    endcase
  end

  assign rd_ok = rda && (level_q != LvlW'(DEPTH));
  assign wr_ok = tbr && (level_q != '0);

  always_comb begin
    state_d    = state_q;
    cfg_sel_d  = cfg_sel_q;
    cfg_done_d = cfg_done_q;
    rr_wr_d    = rr_wr_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    iocs_c     = 1'b0;
    iorw_c     = 1'b1;
    ioaddr_c   = 2'b00;
    drive_c    = 1'b0;
    dout_c     = 8'h00;
    unique case (state_q)
      StCfgLo: begin
        iocs_c   = 1'b1;
        iorw_c   = 1'b0;
        ioaddr_c = 2'b10;
        drive_c  = 1'b1;
        dout_c   = div_sel[7:0];
        state_d  = StGapCfg;
      end
      StGapCfg: state_d = StCfgHi;
      StCfgHi: begin
        iocs_c     = 1'b1;
        iorw_c     = 1'b0;
        ioaddr_c   = 2'b11;
        drive_c    = 1'b1;
        dout_c     = div_sel[15:8];
        cfg_done_d = 1'b1;
        state_d    = StGap;
      end
      StRun: begin
        // Round robin only matters when both sides are eligible.
        if (rd_ok && (!wr_ok || rr_wr_q)) begin
          state_d = StRd;
          rr_wr_d = 1'b0;
        end else if (wr_ok) begin
          state_d = StWr;
          rr_wr_d = 1'b1;
        end
      end
      StRd: begin
        iocs_c  = 1'b1;
        wptr_d  = wptr_q + PtrW'(1);
        level_d = level_q + LvlW'(1);
        state_d = StGap;
      end
      StWr: begin
        iocs_c  = 1'b1;
        iorw_c  = 1'b0;
        drive_c = 1'b1;
        dout_c  = echo_byte(buf_q[rptr_q]);
        rptr_d  = rptr_q + PtrW'(1);
        level_d = level_q - LvlW'(1);
        state_d = StGap;
      end
      StGap: begin
        if (br_cfg != cfg_sel_q) begin
          state_d    = StCfgLo;
          cfg_sel_d  = br_cfg;
          cfg_done_d = 1'b0;
        end else begin
          state_d = StRun;
        end
      end
      default: state_d = StCfgLo;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StCfgLo;
      cfg_sel_q  <= br_cfg;
      cfg_done_q <= 1'b0;
      rr_wr_q    <= 1'b1;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      cfg_sel_q  <= cfg_sel_d;
      cfg_done_q <= cfg_done_d;
      rr_wr_q    <= rr_wr_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
    end
  end

  // Buffer storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (rst && state_q == StRd) begin
      buf_q[wptr_q] <= databus;
    end
  end

  // Gating with rst makes an in-flight access disappear in the reset cycle itself.
  assign iocs      = iocs_c & rst;
  assign iorw      = iorw_c | ~rst;
  assign ioaddr    = rst ? ioaddr_c : 2'b00;
  assign databus   = (drive_c && rst) ? dout_c : 8'hzz;
  assign cfg_done  = cfg_done_q;
  assign buf_level = level_q;

endmodule

// File: tb/tb_spart_echo_ctrl.sv
// Scoreboard bench for spart_echo_ctrl: expected bus accesses are queued, a monitor checks them.
module tb_spart_echo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] br_cfg = 2'b01;
  logic       tbr = 1'b0;
  wire        rda;
  wire        iocs, iorw, cfg_done;
  wire [1:0]  ioaddr;
  wire [7:0]  databus;
  wire [2:0]  buf_level;

  typedef struct packed {
    logic       rw;
    logic [1:0] addr;
    logic [7:0] data;
  } acc_t;

  acc_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] rx_arr [32];
  int         rx_cnt = 0;
  int         rx_idx = 0;
  logic       prev_cs = 1'b0;

  always #5 clk = ~clk;

  spart_echo_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .br_cfg    (br_cfg),
    .rda       (rda),
    .tbr       (tbr),
    .iocs      (iocs),
    .iorw      (iorw),
    .ioaddr    (ioaddr),
    .databus   (databus),
    .cfg_done  (cfg_done),
    .buf_level (buf_level)
  );

  // SPART receive side model
  assign rda     = (rx_idx < rx_cnt);
  assign databus = (iocs && iorw && ioaddr == 2'b00) ? rx_arr[rx_idx[4:0]] : 8'hzz;

  always @(posedge clk) begin
    if (rst && iocs && iorw && ioaddr == 2'b00) rx_idx <= rx_idx + 1;
  end

  always @(negedge clk) begin
    acc_t e;
    if (rst) begin
      if (iocs) begin
        checks++;
        if (prev_cs) begin
          failures++;
          $display("FAIL back_to_back: iocs high in consecutive cycles at %0t, required a gap", $time);
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_access: got rw=%0b addr=%0d data=%h, required no access",
                   iorw, ioaddr, databus);
        end else begin
          e = exp_q.pop_front();
          if (iorw !== e.rw || ioaddr !== e.addr || (!e.rw && databus !== e.data)) begin
            failures++;
            $display("FAIL access: got rw=%0b addr=%0d data=%h, required rw=%0b addr=%0d data=%h",
                     iorw, ioaddr, databus, e.rw, e.addr, e.data);
          end
        end
      end
      prev_cs = iocs;
    end else begin
      prev_cs = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push_w(input logic [1:0] a, input logic [7:0] d);
    exp_q.push_back('{rw: 1'b0, addr: a, data: d});
  endtask

  task automatic push_r();
    exp_q.push_back('{rw: 1'b1, addr: 2'b00, data: 8'h00});
  endtask

  task automatic add_rx(input logic [7:0] b);
    rx_arr[rx_cnt[4:0]] = b;
    rx_cnt++;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: %0d accesses outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (6) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_iocs", 8'(iocs), 8'h00);
    chk("rst_iorw", 8'(iorw), 8'h01);
    chk("rst_ioaddr", 8'(ioaddr), 8'h00);
    chk("rst_cfg_done", 8'(cfg_done), 8'h00);
    chk("rst_level", 8'(buf_level), 8'h00);

    // Divisor programming for br_cfg=01
    push_w(2'b10, 8'h8A);
    push_w(2'b11, 8'h02);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk); chk("cfg_done_cfglo", 8'(cfg_done), 8'h00);
    @(negedge clk);
    @(negedge clk); chk("cfg_done_cfghi", 8'(cfg_done), 8'h00);
    @(negedge clk); chk("cfg_done_gap", 8'(cfg_done), 8'h01);
    wait_idle("cfg");

    // Single echo
    push_r();
    push_w(2'b00, 8'h41);
    add_rx(8'h41);
    tbr = 1'b1;
    @(negedge clk); chk("echo_level_rd", 8'(buf_level), 8'h00);
    @(negedge clk); chk("echo_level_gap", 8'(buf_level), 8'h01);
    wait_idle("echo");
    chk("echo_level_end", 8'(buf_level), 8'h00);

    // Fill to full, then drain; fifth byte waits in SPART
    tbr = 1'b0;
    for (int i = 0; i < 5; i++) add_rx(8'h10 + 8'(i));
    for (int i = 0; i < 4; i++) push_r();
    wait_idle("fill");
    chk("full_level", 8'(buf_level), 8'h04);
    push_w(2'b00, 8'h10);
    push_r();
    for (int i = 1; i < 5; i++) push_w(2'b00, 8'h10 + 8'(i));
    tbr = 1'b1;
    wait_idle("drain");
    chk("drain_level", 8'(buf_level), 8'h00);

    // Round robin with both sides eligible
    tbr = 1'b0;
    add_rx(8'h20);
    add_rx(8'h21);
    push_r();
    push_r();
    wait_idle("rr_pre");
    chk("rr_level", 8'(buf_level), 8'h02);
    push_w(2'b00, 8'h20); push_r();
    push_w(2'b00, 8'h21); push_r();
    push_w(2'b00, 8'h22); push_r();
    push_w(2'b00, 8'h23);
    push_w(2'b00, 8'h24);
    add_rx(8'h22);
    add_rx(8'h23);
    add_rx(8'h24);
    tbr = 1'b1;
    wait_idle("rr");
    chk("rr_level_end", 8'(buf_level), 8'h00);

    // Baud change while a write is in flight
    tbr = 1'b0;
    add_rx(8'h30);
    add_rx(8'h31);
    push_r();
    push_r();
    wait_idle("rebaud_pre");
    chk("rebaud_level", 8'(buf_level), 8'h02);
    push_w(2'b00, 8'h30);
    push_w(2'b10, 8'hA2);
    push_w(2'b11, 8'h00);
    push_w(2'b00, 8'h31);
    tbr = 1'b1;
    @(negedge clk); br_cfg = 2'b11;
    @(negedge clk); chk("rebaud_done_gap", 8'(cfg_done), 8'h01);
    @(negedge clk); chk("rebaud_done_cfglo", 8'(cfg_done), 8'h00);
    wait_idle("rebaud");
    chk("rebaud_done_end", 8'(cfg_done), 8'h01);
    chk("rebaud_level_end", 8'(buf_level), 8'h00);

    // Case conversion
    push_r();
`ifdef UPCASE_ECHO_EN
    push_w(2'b00, 8'h41);
`else
    push_w(2'b00, 8'h61);
`endif
    push_r();
    push_w(2'b00, 8'h5A);
    add_rx(8'h61);
    add_rx(8'h5A);
    wait_idle("upcase");
    chk("upcase_level", 8'(buf_level), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
